onehot_rr_arbiter: RTL and testbench

//  Round-robin arbiter for 8 request lines. Issues a registered one-hot grant

---
 rtl/onehot_rr_arbiter_if.sv | 36 +++
 rtl/onehot_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_if.sv
// onehot_rr_arbiter_if
//   Request/grant handshake bundle for the one-hot round-robin arbiter.
//   Signals:
//     req        requester lines, bit i = requester i
//     gnt        registered one-hot grant (zero when gnt_valid=0)
//     gnt_valid  grant present on gnt
//     gnt_ready  downstream accepts the grant this cycle
//     busy       mirrors gnt_valid
//   Modports:
//     master  arbiter side (drives gnt/gnt_valid/busy)
//     slave   requesters + downstream side (drives req/gnt_ready)
interface onehot_rr_arbiter_if #(
  parameter int N = 8
) ();
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_ready;
  logic         busy;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt,
    output gnt_valid,
    output busy
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt,
    input  gnt_valid,
    input  busy
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//   Round-robin arbiter for N request lines with a registered one-hot grant
//   over a valid/ready handshake. The grant is held until accepted and is
//   never retracted; on acceptance with requests pending it re-arbitrates in
//   the same edge, so a held-high ready gives one grant per cycle.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     arb    onehot_rr_arbiter_if.master (req, gnt, gnt_valid, gnt_ready, busy)
//   Build option:
//     ARB_FIXED_PRIO_EN  when defined, the rotating pointer is removed and the
//                        lowest set request index always wins.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant outstanding, gnt=0, waiting for any request
//   GRANT | gnt holds one one-hot grant, waiting for gnt_ready
module onehot_rr_arbiter #(
  parameter int N     = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_rr_arbiter_if.master  arb
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [N-1:0]     gnt_q;
  logic             gnt_valid_q;
  logic [PTR_W-1:0] arb_base;
  logic [PTR_W-1:0] sel_idx;
  logic             any_req;
  logic             handshake;

  assign any_req   = |arb.req;
  assign handshake = (state == GRANT) && arb.gnt_ready;

`ifdef ARB_FIXED_PRIO_EN
  assign arb_base = '0;
`else
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;

  // On a handshake the pointer update and the re-arbitration happen in the
  // same edge, so search from the post-update value directly.
  assign arb_base = handshake ? gnt_idx + PTR_W'(1) : ptr;
`endif

  // Circular search starting at arb_base; N is a power of two so the
  // PTR_W-bit add wraps N-1 -> 0 on its own.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    sel_idx = arb_base;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = arb_base + PTR_W'(i);
      if (!found && arb.req[idx]) begin
        sel_idx = idx;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr         <= '0;
      gnt_idx     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= GRANT;
            gnt_q       <= N'(1) << sel_idx;
            gnt_valid_q <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            gnt_idx     <= sel_idx;
`endif
          end
        end
        GRANT: begin
          if (arb.gnt_ready) begin
`ifndef ARB_FIXED_PRIO_EN
            ptr <= gnt_idx + PTR_W'(1);
`endif
            if (any_req) begin
              gnt_q <= N'(1) << sel_idx;
`ifndef ARB_FIXED_PRIO_EN
              gnt_idx <= sel_idx;
`endif
            end else begin
              state       <= IDLE;
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_valid = gnt_valid_q;
  assign arb.busy      = gnt_valid_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter
//   Self-checking bench for onehot_rr_arbiter: directed scenarios followed by
//   randomized req/ready traffic, all compared against a behavioural model.
//   Honours ARB_FIXED_PRIO_EN the same way the design does.
module tb_onehot_rr_arbiter;
  localparam int N = 8;

  logic clk;
  logic rst_n;

  onehot_rr_arbiter_if #(.N(N)) bus ();

  onehot_rr_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: whether a grant is outstanding, who holds it, and the
  // requester that gets first look at the next arbitration.
  bit m_valid;
  int m_idx;
  int m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int base);
    int b;
`ifdef ARB_FIXED_PRIO_EN
    b = 0;
`else
    b = base;
`endif
    for (int k = 0; k < N; k++)
      if (r[(b + k) % N]) return (b + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rdy);
    if (!m_valid) begin
      if (r != 0) begin
        m_idx   = pick(r, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % N;
      if (r != 0) m_idx = pick(r, m_ptr);
      else        m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt),       32'(m_gnt()));
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(m_valid));
    chk({tag, ".busy"},  32'(bus.busy),      32'(m_valid));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic [N-1:0] r, input logic rdy, input string tag);
    bus.req       = r;
    bus.gnt_ready = rdy;
    @(posedge clk);
    model_step(r, rdy);
    #1;
    check_outputs(tag);
  endtask

  // Reset is asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Invariant watcher, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt_valid) chk("onehot", 32'($onehot(bus.gnt)), 32'd1);
      else               chk("zero_when_idle", 32'(bus.gnt), 32'd0);
    end
  end

  logic [N-1:0] exp_g;

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.gnt_ready = 1'b0;
    m_valid       = 1'b0;
    m_idx         = 0;
    m_ptr         = 0;
    #12;
    check_outputs("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Ready while idle is ignored.
    cycle(8'h00, 1'b1, "idle_ready");
    chk("idle_ready_gnt", 32'(bus.gnt), 32'h0);

    // Async reset mid-grant, then first arbitration after release.
    cycle(8'h21, 1'b0, "pre_reset");
    do_reset("reset_mid_grant");
    cycle(8'h04, 1'b0, "post_reset");
    chk("post_reset_gnt", 32'(bus.gnt), 32'h04);

    // Rotation with all requests high and ready held.
    do_reset("reset_rot");
    for (int k = 0; k < 9; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 8'h01;
`else
      exp_g = 8'h01 << (k % N);
`endif
      cycle(8'hFF, 1'b1, "rotation");
      chk("rotation_seq", 32'(bus.gnt), 32'(exp_g));
    end

    // Backpressure: grant held, then advances after acceptance.
    do_reset("reset_bp");
    for (int k = 0; k < 6; k++) begin
      cycle(8'h12, 1'b0, "backpressure");
      chk("bp_hold", 32'(bus.gnt), 32'h02);
    end
    cycle(8'h12, 1'b1, "bp_release");
`ifdef ARB_FIXED_PRIO_EN
    chk("bp_next", 32'(bus.gnt), 32'h02);
`else
    chk("bp_next", 32'(bus.gnt), 32'h10);
`endif

    // No retraction when the granted request drops.
    do_reset("reset_retract");
    cycle(8'h08, 1'b0, "retract_get");
    for (int k = 0; k < 3; k++) begin
      cycle(8'h00, 1'b0, "retract_hold");
      chk("retract_hold_gnt", 32'(bus.gnt), 32'h08);
    end
    cycle(8'h00, 1'b1, "retract_release");
    chk("retract_idle_gnt", 32'(bus.gnt), 32'h00);
    chk("retract_idle_valid", 32'(bus.gnt_valid), 32'h0);

    // Wrap: after granting 6 the pointer is 7; index 0 beats index 6.
    do_reset("reset_wrap");
    cycle(8'h40, 1'b0, "wrap_get6");
    chk("wrap_get6_gnt", 32'(bus.gnt), 32'h40);
    cycle(8'h41, 1'b1, "wrap");
    chk("wrap_gnt", 32'(bus.gnt), 32'h01);

    // Randomized traffic, with occasional asynchronous resets.
    do_reset("reset_rand");
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r;
      logic         rdy;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(0, N - 1);
        2:       r = N'($urandom) & N'($urandom);
        default: r = N'($urandom);
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset("rand_reset");
      cycle(r, rdy, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
